// File: rtl/uart_receive.sv
// ---------------------------------------------------------------------------
// uart_receive
//
// UART receiver. It deserializes one frame at a time: one low start bit,
// WIDTH data bits sent LSB first, and one high stop bit. A good frame updates
// data_out and pulses valid_out for one cycle. A frame whose stop bit is
// sampled low pulses framing_error_out for one cycle instead. After a
// framing error the receiver waits for the line to go high again before it
// looks for another start bit.
//
// Parameters
//   INPUT_CLOCK_FREQ : clk_in frequency in Hz
//   BAUD_RATE        : line bit rate in bits/s
//   WIDTH            : data bits per frame (>= 2)
//
// Ports
//   clk_in            in   system clock
//   rst_in            in   synchronous active-high reset
//   rx_wire_in        in   asynchronous serial line, idles high
//   data_out          out  last correctly framed word
//   valid_out         out  one-cycle strobe when data_out updates
//   framing_error_out out  one-cycle strobe on a low stop bit
//   busy_out          out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int WIDTH            = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rx_wire_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             framing_error_out,
    output logic             busy_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;
    localparam int CW              = $clog2(BAUD_BIT_PERIOD);
    localparam int IW              = $clog2(WIDTH);
    localparam int SYNC_STAGES     = 2;

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BAUD_BIT_PERIOD - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Input synchronizer. Both stages reset high so that a reset never looks
    // like a falling start edge.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   rx_s;

    assign sync_next[0] = rx_wire_in;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    assign rx_s = sync_reg[SYNC_STAGES-1];

    state_t           state_reg,  state_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic [IW-1:0]    index_reg,  index_next;
    logic [WIDTH-1:0] shift_reg,  shift_next;
    logic [WIDTH-1:0] data_reg,   data_next;
    logic             valid_reg,  valid_next;
    logic             ferr_reg,   ferr_next;
    logic             busy_reg,   busy_next;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_reg  <= '1;
            state_reg <= IDLE;
            count_reg <= '0;
            index_reg <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            state_reg <= state_next;
            count_reg <= count_next;
            index_reg <= index_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg + 1'b1;
        index_next = index_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            // Re-check the start bit at its middle; a line that has already
            // returned high was only a glitch.
            START: begin
                if (count_reg == HALF_LAST) begin
                    count_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        index_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            // Counting a full bit period from mid-start lands every sample
            // at mid-bit.
            DATA: begin
                if (count_reg == BIT_LAST) begin
                    count_next             = '0;
                    shift_next[index_reg]  = rx_s;
                    if (index_reg == INDEX_LAST) begin
                        state_next = STOP;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end
            end

            // Leaving at mid-stop-bit leaves half a bit of slack to catch a
            // back-to-back start edge.
            STOP: begin
                if (count_reg == BIT_LAST) begin
                    count_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end

            // Break or stuck-low line: do not start a frame until it idles.
            WAIT_IDLE: begin
                count_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase

        // Registered from the next state so busy_out tracks the state register.
        busy_next = (state_next != IDLE);
    end

    assign data_out          = data_reg;
    assign valid_out         = valid_reg;
    assign framing_error_out = ferr_reg;
    assign busy_out          = busy_reg;

endmodule

// File: tb/tb_uart_receive.sv
// ---------------------------------------------------------------------------
// tb_uart_receive
//
// Two receivers at 10 clocks per bit: an 8-bit one for the directed frame
// scenarios and a 16-bit one fed by a behavioural serial transmitter.
// Each frame sent pushes its expected outcome (good word or framing error)
// and the cycle it must appear on into a per-channel queue. A single compare
// process checks both receivers on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_receive;

    localparam int P    = 10;
    localparam int HALF = P / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rx_line [2];

    logic [7:0]  d8;
    logic        v8, f8, b8;
    logic [15:0] d16;
    logic        v16, f16, b16;

    uart_receive #(
        .INPUT_CLOCK_FREQ(1000),
        .BAUD_RATE       (100),
        .WIDTH           (8)
    ) dut8 (
        .clk_in           (clk),
        .rst_in           (rst),
        .rx_wire_in       (rx_line[0]),
        .data_out         (d8),
        .valid_out        (v8),
        .framing_error_out(f8),
        .busy_out         (b8)
    );

    uart_receive #(
        .INPUT_CLOCK_FREQ(1000),
        .BAUD_RATE       (100),
        .WIDTH           (16)
    ) dut16 (
        .clk_in           (clk),
        .rst_in           (rst),
        .rx_wire_in       (rx_line[1]),
        .data_out         (d16),
        .valid_out        (v16),
        .framing_error_out(f16),
        .busy_out         (b16)
    );

    typedef struct {
        logic        fe;
        logic [15:0] data;
        int          due;
    } ev_t;

    ev_t         q0[$];
    ev_t         q1[$];
    logic [15:0] model_d [2];
    int          nvalid [2] = '{0, 0};
    int          nfe [2]    = '{0, 0};
    int          errors     = 0;
    int          checks     = 0;
    int          cyc        = 0;
    bit          checking   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic check_chan(input int ch, input logic v, input logic f, input logic b,
                              input logic [15:0] d);
        ev_t e;
        bit  have;
        have = 1'b0;
        checks++;
        if (v && f) begin
            errors++;
            $display("FAIL strobe_overlap ch%0d: valid=1 framing_error=1 at cycle %0d, required not both", ch, cyc);
        end
        if (ch == 0) begin
            if (q0.size() > 0) begin have = 1'b1; e = q0[0]; end
        end else begin
            if (q1.size() > 0) begin have = 1'b1; e = q1[0]; end
        end
        if (v || f) begin
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected_strobe ch%0d: valid=%0b framing_error=%0b at cycle %0d, required none", ch, v, f, cyc);
            end else begin
                if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (e.fe != f || cyc < e.due - 1 || cyc > e.due + 1) begin
                    errors++;
                    $display("FAIL strobe_event ch%0d: framing_error=%0b at cycle %0d, required framing_error=%0b at cycle %0d+-1",
                             ch, f, cyc, e.fe, e.due);
                end
                if (v) begin
                    model_d[ch] = e.data;
                    nvalid[ch]++;
                end else begin
                    nfe[ch]++;
                end
                checks++;
                if (b !== f) begin
                    errors++;
                    $display("FAIL busy_at_strobe ch%0d: got %0b, required %0b", ch, b, f);
                end
                $display("ch%0d strobe valid=%0b framing_error=%0b data=%0h cycle=%0d", ch, v, f, d, cyc);
            end
        end else if (have && cyc > e.due + 1) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe ch%0d: nothing by cycle %0d, required framing_error=%0b data=%0h at cycle %0d",
                     ch, cyc, e.fe, e.data, e.due);
            if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        checks++;
        if (d !== model_d[ch]) begin
            errors++;
            $display("FAIL data_out ch%0d: got %0h, required %0h at cycle %0d", ch, d, model_d[ch], cyc);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_chan(0, v8, f8, b8, {8'h00, d8});
            check_chan(1, v16, f16, b16, d16);
        end
    end

    // Called just after a rising edge; holds the bit for one bit period.
    task automatic drive_bit(input int ch, input logic b);
        rx_line[ch] = b;
        repeat (P) @(posedge clk);
        #1;
    endtask

    // Outcome appears 2 sync cycles + half bit + (w+1) bit periods + 1 output
    // register cycle after the first rising edge that sees the start bit.
    task automatic send_frame(input int ch, input int w, input logic [15:0] data, input logic stop);
        ev_t e;
        e.fe   = ~stop;
        e.data = data;
        e.due  = cyc + 3 + HALF + (w + 1) * P;
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < w; i++) drive_bit(ch, data[i]);
        drive_bit(ch, stop);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit busy_seen;

    initial begin
        rst        = 1'b1;
        rx_line[0] = 1'b1;
        rx_line[1] = 1'b1;
        model_d[0] = '0;
        model_d[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check("reset_data8",  d8,  0);
        check("reset_valid8", v8,  0);
        check("reset_ferr8",  f8,  0);
        check("reset_busy8",  b8,  0);
        check("reset_data16", d16, 0);
        check("reset_busy16", b16, 0);
        @(posedge clk);
        #1;

        // Good frame
        send_frame(0, 8, 16'h005A, 1'b1);
        wait_cycles(2 * P);
        check("t1_valid_count", nvalid[0], 1);
        check("t1_ferr_count",  nfe[0],    0);
        check("t1_data",        d8,        8'h5A);
        check("t1_model",       model_d[0], 16'h005A);
        check("t1_busy",        b8,        0);

        // Glitch rejection
        rx_line[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_line[0] = 1'b1;
        busy_seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            busy_seen |= b8;
        end
        check("t2_busy_pulse", busy_seen, 1);
        check("t2_busy_after", b8, 0);
        check("t2_valid_count", nvalid[0], 1);
        check("t2_ferr_count",  nfe[0], 0);
        check("t2_data_held",   d8, 8'h5A);
        @(posedge clk);
        #1;

        // Framing error with line held low
        send_frame(0, 8, 16'h0011, 1'b1);
        wait_cycles(P);
        check("t3_good_data", d8, 8'h11);
        send_frame(0, 8, 16'h00C3, 1'b0);
        wait_cycles(30);
        check("t3_ferr_count",  nfe[0], 1);
        check("t3_valid_count", nvalid[0], 2);
        check("t3_data_held",   d8, 8'h11);
        check("t3_busy_low",    b8, 1);
        rx_line[0] = 1'b1;
        wait_cycles(5);
        check("t3_busy_released", b8, 0);
        send_frame(0, 8, 16'h007E, 1'b1);
        wait_cycles(2 * P);
        check("t3_recover_data", d8, 8'h7E);
        check("t3_recover_count", nvalid[0], 3);

        // Back-to-back frames
        send_frame(0, 8, 16'h0000, 1'b1);
        send_frame(0, 8, 16'h00FF, 1'b1);
        send_frame(0, 8, 16'h00A5, 1'b1);
        wait_cycles(2 * P);
        check("t4_valid_count", nvalid[0], 6);
        check("t4_last_data",   d8, 8'hA5);
        check("t4_ferr_count",  nfe[0], 1);

        // Reset during the 4th data bit of 0x96 (bits 0..2 = 0,1,1; bit 3 = 0)
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rx_line[0] = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        rst        = 1'b1;
        rx_line[0] = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_d[0] = '0;
        model_d[1] = '0;
        @(negedge clk);
        check("t5_reset_data",  d8, 0);
        check("t5_reset_valid", v8, 0);
        check("t5_reset_ferr",  f8, 0);
        check("t5_reset_busy",  b8, 0);
        wait_cycles(3 * P);
        check("t5_no_strobe_valid", nvalid[0], 6);
        check("t5_no_strobe_ferr",  nfe[0], 1);
        check("t5_idle_busy", b8, 0);
        send_frame(0, 8, 16'h003C, 1'b1);
        wait_cycles(2 * P);
        check("t5_next_data", d8, 8'h3C);
        check("t5_next_count", nvalid[0], 7);

        // 16-bit receiver fed by a serial transmitter model
        send_frame(1, 16, 16'hBEEF, 1'b1);
        wait_cycles(2 * P);
        check("t6_first_data", d16, 16'hBEEF);
        send_frame(1, 16, 16'h0001, 1'b1);
        wait_cycles(2 * P);
        check("t6_second_data",  d16, 16'h0001);
        check("t6_model",        model_d[1], 16'h0001);
        check("t6_valid_count",  nvalid[1], 2);
        check("t6_ferr_count",   nfe[1], 0);

        wait_cycles(2 * P);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
UART receiver and the counterpart to uart_transmit. It deserializes an asynchronous 8N1-style frame with a parameterized data width: one start bit (low), WIDTH data bits LSB first, and one stop bit (high). It presents the received word with a single-cycle valid strobe. It sits between the board RX pin and downstream consumers, and must interoperate with uart_transmit at matching parameters.

Parameters:
INPUT_CLOCK_FREQ, 100_000_000, clk_in frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
WIDTH, 16, data bits per frame; must be >= 2
Derived (localparam): BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE, which must be >= 4. HALF_PERIOD = BAUD_BIT_PERIOD / 2 (floor).

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rx_wire_in  input  1  asynchronous serial line; idles high
data_out  output  WIDTH  last correctly framed word; held until the next good frame
valid_out  output  1  one-cycle strobe when data_out updates
framing_error_out  output  1  one-cycle strobe when the stop bit is sampled low
busy_out  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high. All outputs are registered.
- Synchronizer: rx_wire_in passes through a 2-flop synchronizer before the FSM sees it; call the result rx_s. Both flops reset to 1, so no false start is detected out of reset. Latency from rx_wire_in to rx_s is 2 cycles.
- Reset values: data_out=0, valid_out=0, framing_error_out=0, busy_out=0, state=IDLE, count=0, index=0, shift register=0.
- Counter: count is $clog2(BAUD_BIT_PERIOD) bits wide and resets to 0 on every state transition.
- Index: index is $clog2(WIDTH) bits wide.
- valid_out and framing_error_out default to 0 every cycle and are never high simultaneously.
- IDLE: if rx_s==0, go to START with count=0. Otherwise stay.
- START: count increments each cycle. At count==HALF_PERIOD-1, sample rx_s:
  - sample 0: go to DATA, count=0, index=0.
  - sample 1: false start (glitch); return to IDLE with no strobes.
- DATA: at count==BAUD_BIT_PERIOD-1, shift[index] <= rx_s and count=0.
  - if index==WIDTH-1, go to STOP; otherwise index increments.
  - Sampling therefore lands at mid-bit for every data bit.
- STOP: at count==BAUD_BIT_PERIOD-1, sample rx_s:
  - sample 1: data_out <= shift, valid_out=1 on the next cycle, go to IDLE.
  - sample 0: framing_error_out=1 on the next cycle, data_out unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This covers break or stuck-low lines, and no new frame is started while rx_s is low. busy_out is high in this state.
- Latency: from the first cycle rx_s==0 to valid_out high is HALF_PERIOD + (WIDTH+1)*BAUD_BIT_PERIOD + 1 cycles, within ±1.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit, so a start edge arriving immediately after the stop bit is caught. There are no dead cycles beyond the remaining half stop bit.
- Reset mid-frame: the FSM aborts to IDLE immediately. The partial word is discarded and no strobe is issued. The synchronizer is re-initialized to 1. A line still low after reset counts as a new start once rx_s reflects it, so the bench must release the line first.
- Unreachable or illegal state: go to IDLE.

Test Plan:
1. Good frame: set INPUT_CLOCK_FREQ=1000, BAUD_RATE=100 (P=10), WIDTH=8. Drive 0x5A, LSB first, with one stop bit. Required: exactly one valid_out pulse, data_out=0x5A, framing_error_out never high, busy_out low after the strobe.
2. Glitch rejection: same parameters. Drive rx_wire_in low for 3 cycles, then high. Required: busy_out pulses, then the FSM returns to IDLE; no valid_out, no framing_error_out; data_out stays at its prior value.
3. Framing error: first receive 0x11 correctly. Then send 0xC3 with the stop bit low, and hold the line low for 30 cycles. Required: one framing_error_out pulse, no valid_out, data_out=0x11, and busy_out high until the line returns high. A following 0x7E frame is then received correctly.
4. Back-to-back: send 0x00, 0xFF, 0xA5 with no idle gap between frames. Required: three valid_out pulses in order with matching data_out values.
5. Reset mid-frame: assert rst_in for 1 cycle during the 4th data bit, then release the line high. Required: all outputs at reset values, no strobe; the next frame 0x3C is received correctly.
6. Loopback with uart_transmit at default parameters (WIDTH=16): send 0xBEEF, then 0x0001. Required: valid_out with data_out=0xBEEF, then 0x0001, and no framing errors.
